// File: rtl/memory_pkg.sv
// Shared constants and helpers for the banked RAM controller: byte width,
// constant-time clog2 and the bank-index extraction used by the address decode.
package memory_pkg;

  localparam int BYTE_W = 8;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Interleaved mode takes the bank from the low word-address bits, linear from the top bits.
  function automatic int unsigned bank_index(input logic [31:0] addr, input int addr_width,
                                             input int bank_bits, input bit interleave);
    logic [31:0] mask;
    mask = (32'd1 << bank_bits) - 32'd1;
    if (interleave) return addr & mask;
    return (addr >> (addr_width - bank_bits)) & mask;
  endfunction

endpackage

// File: rtl/ram_bank_lanes.sv
// One single-port synchronous RAM bank built from independent byte lanes,
// each with its own write enable and a registered read output.
module ram_bank_lanes
  import memory_pkg::*;
#(
  parameter int IDX_W      = 14,
  parameter int DATA_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         en,
  input  logic                         we,
  input  logic [DATA_WIDTH/BYTE_W-1:0] be,
  input  logic [IDX_W-1:0]             addr,
  input  logic [DATA_WIDTH-1:0]        wdata,
  output logic [DATA_WIDTH-1:0]        rdata
);

  localparam int LANES = DATA_WIDTH / BYTE_W;
  localparam int DEPTH = 2 ** IDX_W;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [BYTE_W-1:0] lane_mem [DEPTH];
    logic [BYTE_W-1:0] lane_rdata_reg;

    // Separate arrays per lane map cleanly onto byte-write block RAM.
    always_ff @(posedge clk) begin
      if (en) begin
        if (we) begin
          if (be[gi]) lane_mem[addr] <= wdata[gi*BYTE_W +: BYTE_W];
        end else begin
          lane_rdata_reg <= lane_mem[addr];
        end
      end
    end

    assign rdata[gi*BYTE_W +: BYTE_W] = lane_rdata_reg;
  end

endmodule

// File: rtl/banked_sync_ram_ctrl.sv
// Multi-bank single-port RAM behind a valid/ready request port, with an in-order
// 2-entry response FIFO and credit-based request acceptance.
module banked_sync_ram_ctrl
  import memory_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_BANKS  = 4,
  parameter int INTERLEAVE = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_we,
  input  logic [DATA_WIDTH/BYTE_W-1:0] req_be,
  input  logic [ADDR_WIDTH-1:0]        req_addr,
  input  logic [DATA_WIDTH-1:0]        req_wdata,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [DATA_WIDTH-1:0]        rsp_data
);

  localparam int BANK_BITS = clog2(NUM_BANKS);
  localparam int IDX_W     = ADDR_WIDTH - BANK_BITS;

  logic [BANK_BITS-1:0]  bank_sel;
  logic [BANK_BITS-1:0]  rd_bank_reg;
  logic [IDX_W-1:0]      bank_addr;
  logic [NUM_BANKS-1:0]  bank_en;
  logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];
  logic                  accept;
  logic                  inflight_reg;
  logic                  push;
  logic                  pop;
  logic [1:0]            count_reg;
  logic [2:0]            credit_used;
  logic                  wr_ptr_reg;
  logic                  rd_ptr_reg;
  logic [DATA_WIDTH-1:0] entry_reg [2];

  assign bank_sel = BANK_BITS'(bank_index(32'(req_addr), ADDR_WIDTH, BANK_BITS, INTERLEAVE != 0));

  if (INTERLEAVE != 0) begin : g_il_addr
    assign bank_addr = req_addr[ADDR_WIDTH-1:BANK_BITS];
  end else begin : g_lin_addr
    assign bank_addr = req_addr[IDX_W-1:0];
  end

  // Credits count buffered plus in-flight reads so a read can never overrun the FIFO.
  // Gating with rst_n keeps banks from being written while reset is held.
  assign credit_used = {1'b0, count_reg} + {2'b00, inflight_reg};
  assign req_ready   = rst_n && (credit_used < 3'd2);
  assign accept      = req_valid && req_ready;

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    assign bank_en[gi] = accept && (bank_sel == BANK_BITS'(gi));

    ram_bank_lanes #(
      .IDX_W      (IDX_W),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_bank (
      .clk   (clk),
      .en    (bank_en[gi]),
      .we    (req_we),
      .be    (req_be),
      .addr  (bank_addr),
      .wdata (req_wdata),
      .rdata (bank_rdata[gi])
    );
  end

  assign push      = inflight_reg;
  assign rsp_valid = (count_reg != 2'd0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_data  = entry_reg[rd_ptr_reg];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_reg <= 1'b0;
      rd_bank_reg  <= '0;
      count_reg    <= 2'd0;
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
      entry_reg[0] <= '0;
      entry_reg[1] <= '0;
    end else begin
      inflight_reg <= accept && !req_we;
      if (accept && !req_we) rd_bank_reg <= bank_sel;
      if (push) begin
        entry_reg[wr_ptr_reg] <= bank_rdata[rd_bank_reg];
        wr_ptr_reg            <= ~wr_ptr_reg;
      end
      if (pop) rd_ptr_reg <= ~rd_ptr_reg;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: tb/tb_banked_sync_ram_ctrl.sv
// Scoreboard bench: requests push expected read data, per-DUT monitors pop and
// compare on every response handshake.
module tb_banked_sync_ram_ctrl;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b1;
  logic [BW-1:0] req_be = '0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready, rsp_valid;
  logic [DW-1:0] rsp_data;

  logic          il_req_valid = 1'b0, il_req_we = 1'b0, il_rsp_ready = 1'b1;
  logic [BW-1:0] il_req_be = '0;
  logic [AW-1:0] il_req_addr = '0;
  logic [DW-1:0] il_req_wdata = '0;
  logic          il_req_ready, il_rsp_valid;
  logic [DW-1:0] il_rsp_data;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] il_q[$];

  always #5 clk = ~clk;

  banked_sync_ram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BANKS(4), .INTERLEAVE(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data)
  );

  banked_sync_ram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BANKS(4), .INTERLEAVE(1)) u_dut_il (
    .clk(clk), .rst_n(rst_n), .req_valid(il_req_valid), .req_ready(il_req_ready), .req_we(il_req_we),
    .req_be(il_req_be), .req_addr(il_req_addr), .req_wdata(il_req_wdata), .rsp_valid(il_rsp_valid),
    .rsp_ready(il_rsp_ready), .rsp_data(il_rsp_data)
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Call at posedge+#1; returns at posedge+#1 right after the accepting edge.
  task automatic issue(input logic we, input logic [BW-1:0] be, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input logic [DW-1:0] expd);
    int n = 0;
    req_valid = 1'b1; req_we = we; req_be = be; req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    while (!req_ready && n < 200) begin n++; @(negedge clk); end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL req_timeout: addr %h never accepted", addr);
    end
    @(posedge clk); #1;
    if (!we) exp_q.push_back(expd);
    $display("req we=%0b be=%h addr=%h wdata=%h", we, be, addr, wdata);
    req_valid = 1'b0;
  endtask

  task automatic il_issue(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    int n = 0;
    il_req_valid = 1'b1; il_req_we = we; il_req_be = 4'hF; il_req_addr = addr; il_req_wdata = wdata;
    @(negedge clk);
    while (!il_req_ready && n < 200) begin n++; @(negedge clk); end
    if (!il_req_ready) begin
      checks++; errors++;
      $display("FAIL il_req_timeout: addr %h never accepted", addr);
    end
    @(posedge clk); #1;
    if (!we) il_q.push_back(wdata);
    $display("il req we=%0b addr=%h data=%h", we, addr, wdata);
    il_req_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rsp_unexpected: got data %h with nothing outstanding", rsp_data);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        $display("rsp data=%h expected=%h", rsp_data, e);
        check("rsp_data", rsp_data, e);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && il_rsp_valid && il_rsp_ready) begin
      if (il_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL il_rsp_unexpected: got data %h with nothing outstanding", il_rsp_data);
      end else begin
        logic [DW-1:0] e;
        e = il_q.pop_front();
        $display("il rsp data=%h expected=%h", il_rsp_data, e);
        check("il_rsp_data", il_rsp_data, e);
      end
    end
  end

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || il_q.size() != 0) && n < 100) begin n++; @(posedge clk); end
    #1;
    check("drain_main", DW'(exp_q.size()), '0);
    check("drain_il", DW'(il_q.size()), '0);
  endtask

  initial begin
    // 1: reset held with a pending write
    req_valid = 1'b1; req_we = 1'b1; req_be = 4'hF; req_addr = 16'h0020; req_wdata = 32'hFFFF_FFFF;
    repeat (5) begin
      @(negedge clk);
      check("reset_rsp_valid", DW'(rsp_valid), '0);
      check("reset_rsp_data", rsp_data, '0);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", DW'(req_ready), 32'd1);
    check("no_rsp_after_reset", DW'(rsp_valid), '0);
    @(posedge clk); #1;

    // 2: full write then read with latency check
    issue(1'b1, 4'hF, 16'h0000, 32'hDEAD_BEEF, '0);
    issue(1'b0, 4'h0, 16'h0000, '0, 32'hDEAD_BEEF);
    @(negedge clk);
    check("lat_edge_t", DW'(rsp_valid), '0);
    @(negedge clk);
    check("lat_edge_t1", DW'(rsp_valid), 32'd1);
    @(posedge clk); #1;

    // 3: byte-enable merge
    issue(1'b1, 4'hF, 16'h0010, 32'h1122_3344, '0);
    issue(1'b1, 4'b0101, 16'h0010, 32'hAABB_CCDD, '0);
    issue(1'b1, 4'h0, 16'h0010, 32'h0000_0000, '0);
    issue(1'b0, 4'h0, 16'h0010, '0, 32'h11BB_33DD);

    // 4: linear bank boundary
    issue(1'b1, 4'hF, 16'h3FFF, 32'h0000_000A, '0);
    issue(1'b1, 4'hF, 16'h4000, 32'h0000_000B, '0);
    issue(1'b0, 4'h0, 16'h3FFF, '0, 32'h0000_000A);
    issue(1'b0, 4'h0, 16'h4000, '0, 32'h0000_000B);
    drain();
    @(posedge clk); #1;

    // 5: back-pressure, third read must wait
    rsp_ready = 1'b0;
    issue(1'b0, 4'h0, 16'h0000, '0, 32'hDEAD_BEEF);
    issue(1'b0, 4'h0, 16'h0010, '0, 32'h11BB_33DD);
    fork
      issue(1'b0, 4'h0, 16'h3FFF, '0, 32'h0000_000A);
      begin
        repeat (4) begin
          @(negedge clk);
          check("bp_req_ready", DW'(req_ready), '0);
          check("bp_rsp_valid", DW'(rsp_valid), 32'd1);
          check("bp_rsp_stable", rsp_data, 32'hDEAD_BEEF);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
      end
    join
    drain();
    @(posedge clk); #1;

    // 4b: interleaved instance, consecutive addresses across all banks
    for (int i = 0; i < 8; i++) il_issue(1'b1, AW'(i), 32'hC0DE_0000 + DW'(i * 17));
    for (int i = 0; i < 8; i++) il_issue(1'b0, AW'(i), 32'hC0DE_0000 + DW'(i * 17));
    drain();
    @(posedge clk); #1;

    // 6: reset one cycle after a read is accepted
    issue(1'b0, 4'h0, 16'h0010, '0, 32'h11BB_33DD);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("post_reset_quiet", DW'(rsp_valid), '0);
    end
    @(posedge clk); #1;
    issue(1'b0, 4'h0, 16'h0000, '0, 32'hDEAD_BEEF);
    issue(1'b0, 4'h0, 16'h4000, '0, 32'h0000_000B);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
